// File: rtl/aes128_iter_core.sv
// aes128_iter_core: iterative AES-128 encryption core.
//
// Accepts a plaintext block and cipher key with a valid/ready handshake and produces the
// ciphertext with a valid/ready handshake. After the initial key add, UNROLL cipher rounds are
// evaluated per clock. Round keys are derived on the fly from the current round key register,
// so only one 128-bit round key is kept.
//
// Parameters
//   UNROLL     rounds per clock; 1, 2, 5 or 10
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   word/key offered
//   in_ready   core can accept word/key
//   word       plaintext block, byte 0 in [127:120]
//   key        cipher key, same byte order
//   out_valid  roundWord holds a finished ciphertext
//   out_ready  downstream accepts roundWord
//   roundWord  ciphertext; stable while out_valid && !out_ready
//   busy       high while rounds are being computed
module aes128_iter_core #(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] word,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] roundWord,
  output logic         busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : gen_bad_unroll
    $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // ---------------------------------------------------------------------------------------------
  // AES primitives
  // ---------------------------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // S-box computed algebraically: multiplicative inverse (x^254, which maps 0 to 0) followed by
  // the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(x, x);
    inv = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    unique case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // SubBytes and ShiftRows together. Byte i sits at row i%4, column i/4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    int row;
    int col;
    int src;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      row = i % 4;
      col = i / 4;
      src = 4 * ((col + row) % 4) + row;
      o[127-8*i -: 8] = sbox(s[127-8*src -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // One key schedule step: previous round key -> key for round r.
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96] ^ {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])}
       ^ {rcon(r), 24'h000000};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    t  = w3;
    return {w0, w1, w2, t};
  endfunction

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  state_e       state_q, state_d;
  logic [127:0] data_q, data_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] word_q, word_d;

  logic [127:0] chain_data;
  logic [127:0] chain_key;
  logic         last_step;

  // Rounds rnd_q .. rnd_q+UNROLL-1 chained combinationally.
  always_comb begin
    logic [127:0] d;
    logic [127:0] k;
    logic [3:0]   r;
    d = data_q;
    k = key_q;
    r = rnd_q;
    for (int u = 0; u < int'(UNROLL); u++) begin
      k = next_key(k, r);
      d = sub_shift(d);
      if (r != 4'd10) d = mix_columns(d);
      d = d ^ k;
      r = r + 4'd1;
    end
    chain_data = d;
    chain_key  = k;
  end

  // This step finishes round 10.
  assign last_step = (rnd_q == 4'(11 - UNROLL));

  always_comb begin
    logic load;
    state_d   = state_q;
    data_d    = data_q;
    key_d     = key_q;
    rnd_d     = rnd_q;
    word_d    = word_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) load = 1'b1;
      end
      StRun: begin
        busy   = 1'b1;
        data_d = chain_data;
        key_d  = chain_key;
        if (last_step) begin
          // rnd_q is left at the last step start so it never exceeds 10.
          word_d  = chain_data;
          state_d = StDone;
        end else begin
          rnd_d = rnd_q + 4'(UNROLL);
        end
      end
      StDone: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
            rnd_d   = 4'd0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      data_d  = word ^ key;
      key_d   = key;
      rnd_d   = 4'd1;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      key_q   <= '0;
      rnd_q   <= 4'd0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      word_q  <= word_d;
    end
  end

  assign roundWord = word_q;

  rnd_range_a : assert property (@(posedge clk) disable iff (rst) rnd_q <= 4'd10);

  out_hold_a : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(roundWord)));

endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed testbench for aes128_iter_core: FIPS-197 vectors, latency for every UNROLL,
// backpressure, back-to-back issue, asynchronous reset mid-run and input changes after accept.
module tb_aes128_iter_core;

  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // UNROLL=1 instance
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] word, key, round_word;

  // UNROLL=2,5,10 instances share one input side
  logic         x_valid, x_out_ready;
  logic [127:0] x_word, x_key;
  logic         x_in_ready  [3];
  logic         x_out_valid [3];
  logic         x_busy      [3];
  logic [127:0] x_rw        [3];

  int n_checks = 0;
  int n_fail   = 0;

  aes128_iter_core #(.UNROLL(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .word(word), .key(key),
    .out_valid(out_valid), .out_ready(out_ready), .roundWord(round_word), .busy(busy)
  );

  aes128_iter_core #(.UNROLL(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(x_in_ready[0]), .word(x_word),
    .key(x_key), .out_valid(x_out_valid[0]), .out_ready(x_out_ready), .roundWord(x_rw[0]),
    .busy(x_busy[0])
  );

  aes128_iter_core #(.UNROLL(5)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(x_in_ready[1]), .word(x_word),
    .key(x_key), .out_valid(x_out_valid[1]), .out_ready(x_out_ready), .roundWord(x_rw[1]),
    .busy(x_busy[1])
  );

  aes128_iter_core #(.UNROLL(10)) u_dut10 (
    .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(x_in_ready[2]), .word(x_word),
    .key(x_key), .out_valid(x_out_valid[2]), .out_ready(x_out_ready), .roundWord(x_rw[2]),
    .busy(x_busy[2])
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges until out_valid on the UNROLL=1 instance, bounded.
  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat [3];
    int unr [3];
    lat = '{5, 2, 1};
    unr = '{2, 5, 10};

    in_valid = 1'b0; word = '0; key = '0; out_ready = 1'b0;
    x_valid = 1'b0; x_word = '0; x_key = '0; x_out_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset roundWord", round_word, '0);
    rst = 1'b0;
    tick();

    // App.B, with input change during RUN, then backpressure in DONE
    in_valid = 1'b1; word = PtB; key = KeyB;
    tick();
    check("B busy after accept", busy, 1'b1);
    check("B in_ready in run", in_ready, 1'b0);
    word = '1; key = '1;  // in_valid stays high: must be ignored in RUN and DONE w/o out_ready
    wait_out(n);
    check("B latency", n, 10);
    check("B ciphertext", round_word, CtB);
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("bp out_valid %0d", i), out_valid, 1'b1);
      check($sformatf("bp roundWord %0d", i), round_word, CtB);
      check($sformatf("bp in_ready %0d", i), in_ready, 1'b0);
      check($sformatf("bp busy %0d", i), busy, 1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("drain out_valid", out_valid, 1'b0);
    check("drain in_ready", in_ready, 1'b1);

    // Back-to-back: B then C.1 with out_ready held high
    in_valid = 1'b1; word = PtB; key = KeyB;
    tick();
    word = PtC; key = KeyC;
    wait_out(n);
    check("b2b first latency", n, 10);
    check("b2b first ciphertext", round_word, CtB);
    check("b2b in_ready in done", in_ready, 1'b1);
    tick();
    check("b2b second accepted busy", busy, 1'b1);
    check("b2b out_valid dropped", out_valid, 1'b0);
    in_valid = 1'b0; word = '0; key = '0;
    wait_out(n);
    check("b2b period", n + 1, 11);
    check("b2b second ciphertext", round_word, CtC);
    tick();
    check("b2b idle out_valid", out_valid, 1'b0);

    // Asynchronous reset mid-RUN
    out_ready = 1'b0;
    in_valid = 1'b1; word = PtC; key = KeyC;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("mid-run busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst out_valid", out_valid, 1'b0);
    check("async rst in_ready", in_ready, 1'b1);
    check("async rst busy", busy, 1'b0);
    check("async rst roundWord", round_word, '0);
    tick();
    rst = 1'b0;
    tick();
    in_valid = 1'b1; word = PtC; key = KeyC;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    check("post-rst latency", n, 10);
    check("post-rst ciphertext", round_word, CtC);
    out_ready = 1'b1;
    tick();
    check("post-rst drain", out_valid, 1'b0);

    // App.C.1 on UNROLL = 2, 5, 10: latency 10/UNROLL, held under backpressure
    x_valid = 1'b1; x_word = PtC; x_key = KeyC;
    tick();
    x_valid = 1'b0; x_word = '1; x_key = '1;
    for (int j = 0; j < 3; j++) check($sformatf("u%0d busy", unr[j]), x_busy[j], 1'b1);
    for (int e = 1; e <= 10; e++) begin
      tick();
      for (int j = 0; j < 3; j++) begin
        check($sformatf("u%0d out_valid edge %0d", unr[j], e), x_out_valid[j], e >= lat[j]);
      end
    end
    for (int j = 0; j < 3; j++) check($sformatf("u%0d ciphertext", unr[j]), x_rw[j], CtC);
    x_out_ready = 1'b1;
    tick();
    for (int j = 0; j < 3; j++) check($sformatf("u%0d drain", unr[j]), x_out_valid[j], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
